// File: rtl/pll_drp_reconfig_if.sv
// Host register-bus, DRP and PLL control signals of the PLLE2_ADV reconfiguration engine.
// The slave modport is the engine's view; the master modport is the host/PLL side.
interface pll_drp_reconfig_if #(
    parameter int TBL_AW = 5
);
    logic              tbl_we;
    logic [TBL_AW-1:0] tbl_addr;
    logic [38:0]       tbl_wdata;
    logic              cfg_start;
    logic [TBL_AW:0]   cfg_len;
    logic              cfg_busy;
    logic              cfg_done;
    logic              cfg_err;
    logic [1:0]        cfg_err_code;
    logic              drp_den;
    logic              drp_dwe;
    logic [6:0]        drp_daddr;
    logic [15:0]       drp_di;
    logic [15:0]       drp_do;
    logic              drp_drdy;
    logic              pll_rst;
    logic              pll_locked;

    modport slave (
        input  tbl_we, tbl_addr, tbl_wdata, cfg_start, cfg_len,
        input  drp_do, drp_drdy, pll_locked,
        output cfg_busy, cfg_done, cfg_err, cfg_err_code,
        output drp_den, drp_dwe, drp_daddr, drp_di, pll_rst
    );

    modport master (
        output tbl_we, tbl_addr, tbl_wdata, cfg_start, cfg_len,
        output drp_do, drp_drdy, pll_locked,
        input  cfg_busy, cfg_done, cfg_err, cfg_err_code,
        input  drp_den, drp_dwe, drp_daddr, drp_di, pll_rst
    );
endinterface

// File: rtl/pll_drp_reconfig.sv
// DRP initiator: holds the PLL in reset, read-modify-writes each table entry over DRP,
// releases reset and waits for a synchronized lock, then reports done/error to the host.
module pll_drp_reconfig #(
    parameter int TBL_AW   = 5,
    parameter int DRDY_TO  = 64,
    parameter int LOCK_TO  = 65536,
    parameter int RST_HOLD = 16
) (
    input  logic                  clk,
    input  logic                  rstn,
    pll_drp_reconfig_if.slave     bus
);
    localparam int CNT_MAX = (LOCK_TO > DRDY_TO)
                           ? ((LOCK_TO > RST_HOLD) ? LOCK_TO : RST_HOLD)
                           : ((DRDY_TO > RST_HOLD) ? DRDY_TO : RST_HOLD);
    localparam int CNT_W = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0]  C_HOLD  = CNT_W'(RST_HOLD - 1);
    localparam logic [CNT_W-1:0]  C_DRDY  = CNT_W'(DRDY_TO - 1);
    localparam logic [CNT_W-1:0]  C_LOCK  = CNT_W'(LOCK_TO - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE = 1;
    localparam logic [TBL_AW:0]   IDX_ONE = 1;

    typedef enum logic [3:0] {
        S_IDLE, S_RST_WAIT, S_RD_REQ, S_RD_WAIT, S_WR_REQ,
        S_WR_WAIT, S_NEXT, S_LOCK_WAIT, S_FINISH
    } state_t;

    state_t            r_state, w_state_nxt;
    logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
    logic [TBL_AW:0]   r_idx, w_idx_nxt;
    logic [TBL_AW:0]   r_len, w_len_nxt;
    logic [1:0]        r_err_code, w_err_code_nxt;
    logic              r_pll_rst, w_pll_rst_nxt;
    logic              r_lock_s1, r_lock_s2;
    logic [15:0]       r_rdata;
    logic [38:0]       r_tbl [0:(1<<TBL_AW)-1];

    logic [38:0]       w_entry;
    logic [15:0]       w_mask, w_data, w_merge;
    logic [TBL_AW:0]   w_idx_inc;
    logic              w_den;

    always_ff @(posedge clk) begin
        if (bus.tbl_we) begin
            r_tbl[bus.tbl_addr] <= bus.tbl_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (r_state == S_RD_WAIT && bus.drp_drdy) begin
            r_rdata <= bus.drp_do;
        end
    end

    // pll_locked comes from the PLL's own clock domain
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_lock_s1 <= 1'b0;
            r_lock_s2 <= 1'b0;
        end else begin
            r_lock_s1 <= bus.pll_locked;
            r_lock_s2 <= r_lock_s1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_idx      <= '0;
            r_len      <= '0;
            r_err_code <= 2'd0;
            r_pll_rst  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_idx      <= w_idx_nxt;
            r_len      <= w_len_nxt;
            r_err_code <= w_err_code_nxt;
            r_pll_rst  <= w_pll_rst_nxt;
        end
    end

    assign w_entry   = r_tbl[r_idx[TBL_AW-1:0]];
    assign w_mask    = w_entry[31:16];
    assign w_data    = w_entry[15:0];
    // A set mask bit keeps the bit currently in the PLL register
    assign w_merge   = (r_rdata & w_mask) | (w_data & ~w_mask);
    assign w_idx_inc = r_idx + IDX_ONE;

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_idx_nxt      = r_idx;
        w_len_nxt      = r_len;
        w_err_code_nxt = r_err_code;
        w_pll_rst_nxt  = r_pll_rst;
        case (r_state)
            S_IDLE: begin
                if (bus.cfg_start) begin
                    w_len_nxt      = bus.cfg_len;
                    w_err_code_nxt = 2'd0;
                    w_cnt_nxt      = '0;
                    w_idx_nxt      = '0;
                    if (bus.cfg_len == '0) begin
                        w_state_nxt = S_FINISH;
                    end else begin
                        w_pll_rst_nxt = 1'b1;
                        w_state_nxt   = S_RST_WAIT;
                    end
                end
            end
            S_RST_WAIT: begin
                if (r_cnt == C_HOLD) w_state_nxt = S_RD_REQ;
                else                 w_cnt_nxt   = r_cnt + CNT_ONE;
            end
            S_RD_REQ: begin
                w_cnt_nxt   = '0;
                w_state_nxt = S_RD_WAIT;
            end
            S_RD_WAIT, S_WR_WAIT: begin
                if (bus.drp_drdy) begin
                    w_state_nxt = (r_state == S_RD_WAIT) ? S_WR_REQ : S_NEXT;
                end else if (r_cnt == C_DRDY) begin
                    w_err_code_nxt = 2'd1;
                    w_pll_rst_nxt  = 1'b0;
                    w_state_nxt    = S_FINISH;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end
            end
            S_WR_REQ: begin
                w_cnt_nxt   = '0;
                w_state_nxt = S_WR_WAIT;
            end
            S_NEXT: begin
                w_idx_nxt = w_idx_inc;
                if (w_idx_inc == r_len) begin
                    w_pll_rst_nxt = 1'b0;
                    w_cnt_nxt     = '0;
                    w_state_nxt   = S_LOCK_WAIT;
                end else begin
                    w_state_nxt = S_RD_REQ;
                end
            end
            S_LOCK_WAIT: begin
                if (r_lock_s2) begin
                    w_state_nxt = S_FINISH;
                end else if (r_cnt == C_LOCK) begin
                    w_err_code_nxt = 2'd2;
                    w_state_nxt    = S_FINISH;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end
            end
            S_FINISH: begin
                w_pll_rst_nxt = 1'b0;
                w_state_nxt   = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign w_den            = (r_state == S_RD_REQ) || (r_state == S_WR_REQ);
    assign bus.drp_den      = w_den;
    assign bus.drp_dwe      = (r_state == S_WR_REQ);
    assign bus.drp_daddr    = w_den ? w_entry[38:32] : 7'd0;
    assign bus.drp_di       = (r_state == S_WR_REQ) ? w_merge : 16'd0;
    assign bus.cfg_busy     = (r_state != S_IDLE) && (r_state != S_FINISH);
    assign bus.cfg_done     = (r_state == S_FINISH);
    assign bus.cfg_err      = (r_err_code != 2'd0);
    assign bus.cfg_err_code = r_err_code;
    assign bus.pll_rst      = r_pll_rst;
endmodule
